mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Writeback pipeline stage directly downstream of the 256x8 data memory.
- Captures ALU result and control for each instruction leaving execute, and aligns them with the data memory's registered read data, which arrives one cycle later.
- Selects ALU result or loaded byte and issues a single-cycle register-file write.
- Exports load-pending information for decode hazard detection and a retired-writeback counter.

Parameters:
- DATA_W, 8, datapath width; matches memory word.
- RD_W, 3, destination register index width (8-entry register file).
- CNT_W, 16, width of writeback counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents an instruction this cycle.
- in_reg_write  input  1  instruction writes the register file.
- in_mem_to_reg  input  1  1 = load (write data from memory), 0 = write ALU result.
- in_rd  input  RD_W  destination register.
- aluout_in  input  DATA_W  ALU result, same cycle as in_valid.
- memtoreg_in  input  DATA_W  data memory read output; valid the cycle after the load is accepted.
- stall_in  input  1  global hold from hazard/control unit.
- wb_en  output  1  register-file write strobe, one cycle per writeback.
- wb_rd  output  RD_W  register-file write address.
- wb_data  output  DATA_W  register-file write data.
- load_pending  output  1  a load occupies the capture slot (s1).
- load_rd  output  RD_W  destination of that load.
- wb_count  output  CNT_W  number of writebacks issued since reset.

Behaviour:
- Reset (rst=1 at a rising edge):
  - s1_valid, ld_cap, wb_en, load_pending, wb_count all clear to 0.
  - wb_rd, wb_data, load_rd and all internal registers clear to 0.
  - Reset mid-operation discards the in-flight instruction; no write is issued for it.
- Stage s1 (capture):
  - At each edge with stall_in=0, s1 loads in_valid, in_reg_write, in_mem_to_reg, in_rd and aluout_in.
  - If in_valid=0, s1_valid becomes 0 (bubble).
  - When stall_in=1, s1 holds all of its state.
  - Upstream holds its inputs while stalled; the block never accepts an input during a stall.
- Load data alignment:
  - Load accepted at edge E (end of cycle N); memtoreg_in is valid during cycle N+1.
  - Load source = ld_cap ? ld_buf : memtoreg_in.
  - If s1 holds a valid load, ld_cap=0 and stall_in=1 at an edge: ld_buf <= memtoreg_in and ld_cap <= 1.
  - Purpose: a later memory access cannot corrupt a stalled load.
  - ld_cap clears whenever s1 advances (stall_in=0).
- Writeback (registered):
  - At an edge with stall_in=0: wb_en <= s1_valid & s1_reg_write; wb_rd <= s1_rd.
  - wb_data <= s1_mem_to_reg ? load source : s1_alu.
  - Stores and non-writing instructions (reg_write=0) produce wb_en=0; wb_rd/wb_data still update.
  - At an edge with stall_in=1: wb_en <= 0; wb_rd and wb_data hold, so no duplicate write is issued.
- Latency:
  - Instruction accepted at edge E appears on wb_* during the cycle after edge E+1 (2 cycles), plus one cycle per stalled edge while it sits in s1.
  - Throughput is 1 per cycle when unstalled.
- load_pending / load_rd:
  - load_pending = s1_valid & s1_reg_write & s1_mem_to_reg (combinational from s1).
  - load_rd = s1_rd.
- wb_count:
  - Increments by 1 at each edge where wb_en is 1 (i.e. counts cycles with a write strobe).
  - Wraps from 2^CNT_W-1 to 0.
  - Reset has priority over increment.
- Simultaneous events:
  - rst has priority over stall_in, which has priority over in_valid.
  - Back-to-back writes to the same rd issue in order, one per cycle.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 -> wb_en=0, wb_count=0, load_pending=0, wb_data=0x00 after release.
- ALU op: accept rd=3, alu=0x5A, reg_write=1, mem_to_reg=0, no stall -> two cycles later wb_en=1 for exactly 1 cycle, wb_rd=3, wb_data=0x5A, wb_count=1.
- Load: accept rd=5, mem_to_reg=1; drive memtoreg_in=0xC3 on the next cycle only -> load_pending=1 with load_rd=5 for one cycle, then wb_en=1, wb_rd=5, wb_data=0xC3.
- Stalled load:
  - Accept load rd=2; next cycle memtoreg_in=0x11 with stall_in=1 for 3 cycles, then change memtoreg_in to 0xFF and release.
  - Required: wb_data=0x11, wb_en=0 throughout the stall, then exactly one wb_en pulse.
- Store/bubble mix: sequence ALU(rd1,0x01), store (reg_write=0), in_valid=0, load(rd4,0x7E) -> wb_en pulses only for rd1 and rd4, in order; wb_count=2.
- Counter wrap and reset mid-flight:
  - Preload via 65535 back-to-back ALU ops, then issue one more -> wb_count=0.
  - Assert rst while a load is in s1 -> no wb_en for that load.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//
// Purpose:
//   Bundles the execute-side capture inputs, the data memory read return, the
//   global stall and the register-file writeback / hazard outputs of the
//   mem_wb_stage block into one interface.
//
// Signals:
//   in_valid, in_reg_write, in_mem_to_reg, in_rd, aluout_in
//                  instruction leaving execute (driven by the master)
//   memtoreg_in    registered data memory read data (driven by the master)
//   stall_in       global hold from hazard/control (driven by the master)
//   wb_en, wb_rd, wb_data
//                  register-file write port (driven by the slave)
//   load_pending, load_rd
//                  load occupancy of the capture slot (driven by the slave)
//   wb_count       retired writeback counter (driven by the slave)
//
// Modports:
//   master - the pipeline/control side that feeds the stage
//   slave  - the mem_wb_stage block itself
// ---------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] aluout_in;
  logic [DATA_W-1:0] memtoreg_in;
  logic              stall_in;

  logic              wb_en;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              load_pending;
  logic [RD_W-1:0]   load_rd;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output in_valid,
    output in_reg_write,
    output in_mem_to_reg,
    output in_rd,
    output aluout_in,
    output memtoreg_in,
    output stall_in,
    input  wb_en,
    input  wb_rd,
    input  wb_data,
    input  load_pending,
    input  load_rd,
    input  wb_count
  );

  modport slave (
    input  in_valid,
    input  in_reg_write,
    input  in_mem_to_reg,
    input  in_rd,
    input  aluout_in,
    input  memtoreg_in,
    input  stall_in,
    output wb_en,
    output wb_rd,
    output wb_data,
    output load_pending,
    output load_rd,
    output wb_count
  );

endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Purpose:
//   Writeback stage sitting directly behind the 256x8 data memory. Each
//   instruction leaving execute is captured into slot s1 together with its
//   ALU result. Because the memory returns read data one cycle after the
//   load is accepted, the stage picks that data up while the load sits in s1
//   and then issues a single-cycle register-file write.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        mem_wb_stage_if slave modport:
//                in_valid/in_reg_write/in_mem_to_reg/in_rd/aluout_in
//                  - instruction presented by execute
//                memtoreg_in  - memory read data, valid cycle after accept
//                stall_in     - global hold; s1 and the write port freeze
//                wb_en/wb_rd/wb_data - register-file write port
//                load_pending/load_rd - load occupying s1 (decode hazards)
//                wb_count     - number of write strobes since reset
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_wb_stage_if.slave bus
);

  // Capture slot s1
  logic              s1_valid_q,      s1_valid_d;
  logic              s1_reg_write_q,  s1_reg_write_d;
  logic              s1_mem_to_reg_q, s1_mem_to_reg_d;
  logic [RD_W-1:0]   s1_rd_q,         s1_rd_d;
  logic [DATA_W-1:0] s1_alu_q,        s1_alu_d;

  // Load data buffer used while a load is held in s1
  logic              ld_cap_q,        ld_cap_d;
  logic [DATA_W-1:0] ld_buf_q,        ld_buf_d;

  // Writeback register and counter
  logic              wb_en_q,         wb_en_d;
  logic [RD_W-1:0]   wb_rd_q,         wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,       wb_data_d;
  logic [CNT_W-1:0]  wb_count_q,      wb_count_d;

  logic              s1_is_load;
  logic [DATA_W-1:0] load_src;

  // The memory read data is only guaranteed during the single cycle after
  // the load was accepted. Once the load has been held across a stalled edge
  // the buffered copy is the authoritative value, since the memory may have
  // been driven by a later access in the meantime.
  assign s1_is_load = s1_valid_q & s1_mem_to_reg_q;
  assign load_src   = ld_cap_q ? ld_buf_q : bus.memtoreg_in;

  // s1 next state: load fresh inputs when the pipeline advances, otherwise
  // freeze. A bubble (in_valid=0) simply clears s1_valid.
  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_reg_write_d  = s1_reg_write_q;
    s1_mem_to_reg_d = s1_mem_to_reg_q;
    s1_rd_d         = s1_rd_q;
    s1_alu_d        = s1_alu_q;
    if (!bus.stall_in) begin
      s1_valid_d      = bus.in_valid;
      s1_reg_write_d  = bus.in_reg_write;
      s1_mem_to_reg_d = bus.in_mem_to_reg;
      s1_rd_d         = bus.in_rd;
      s1_alu_d        = bus.aluout_in;
    end
  end

  // Load buffer: grab the memory data at the first stalled edge that a load
  // spends in s1, and drop the capture flag as soon as s1 advances.
  always_comb begin
    ld_cap_d = ld_cap_q;
    ld_buf_d = ld_buf_q;
    if (!bus.stall_in) begin
      ld_cap_d = 1'b0;
    end else if (s1_is_load && !ld_cap_q) begin
      ld_cap_d = 1'b1;
      ld_buf_d = bus.memtoreg_in;
    end
  end

  // Writeback register: a stalled edge kills the strobe but keeps address
  // and data so the instruction still in s1 is not written twice.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (!bus.stall_in) begin
      wb_en_d   = s1_valid_q & s1_reg_write_q;
      wb_rd_d   = s1_rd_q;
      wb_data_d = s1_mem_to_reg_q ? load_src : s1_alu_q;
    end
  end

  // Counter of cycles with an active write strobe; wraps naturally.
  always_comb begin
    wb_count_d = wb_count_q + CNT_W'(wb_en_q);
  end

  // State registers with synchronous reset; reset discards anything in
  // flight so no write is ever issued for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_reg_write_q  <= 1'b0;
      s1_mem_to_reg_q <= 1'b0;
      s1_rd_q         <= '0;
      s1_alu_q        <= '0;
      ld_cap_q        <= 1'b0;
      ld_buf_q        <= '0;
      wb_en_q         <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      wb_count_q      <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_reg_write_q  <= s1_reg_write_d;
      s1_mem_to_reg_q <= s1_mem_to_reg_d;
      s1_rd_q         <= s1_rd_d;
      s1_alu_q        <= s1_alu_d;
      ld_cap_q        <= ld_cap_d;
      ld_buf_q        <= ld_buf_d;
      wb_en_q         <= wb_en_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      wb_count_q      <= wb_count_d;
    end
  end

  assign bus.wb_en        = wb_en_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_count     = wb_count_q;
  assign bus.load_pending = s1_is_load & s1_reg_write_q;
  assign bus.load_rd      = s1_rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Purpose:
//   Directed bench for mem_wb_stage. Every instruction that should produce a
//   register write pushes its (rd, data) pair onto a scoreboard queue; a
//   negedge monitor pops and compares on each wb_en strobe and flags any
//   strobe that has no expected entry.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int DATA_W = 8;
  localparam int RD_W   = 3;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_item_t;

  logic clk = 1'b0;
  logic rst;

  wb_item_t sb[$];
  int assertsRun = 0;
  int failures   = 0;
  int wbSeen     = 0;
  int wbMark     = 0;

  mem_wb_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  mem_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counted, asserted, reported on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertsRun++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction (or bubble) onto the execute-side inputs.
  task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                               input logic [RD_W-1:0] rd,
                               input logic [DATA_W-1:0] alu);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_rd         = rd;
    bus.aluout_in     = alu;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pushExp(input logic [RD_W-1:0] rd,
                         input logic [DATA_W-1:0] data);
    wb_item_t it;
    it.rd   = rd;
    it.data = data;
    sb.push_back(it);
  endtask

  // Advance one clock; inputs change and outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    wbMark = wbSeen;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wb_en === 1'b1) begin
      wb_item_t it;
      wbSeen++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_wb_en", 32'(bus.wb_en), 32'd0);
      end else begin
        it = sb.pop_front();
        checkOutput("sb_wb_rd",   32'(bus.wb_rd),   32'(it.rd));
        checkOutput("sb_wb_data", 32'(bus.wb_data), 32'(it.data));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.stall_in    = 1'b0;
    bus.memtoreg_in = '0;

    // Reset held two cycles with a valid instruction presented
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 8'hAA);
    step();
    step();
    rst = 1'b0;
    idle();
    checkOutput("rst_wb_en",        32'(bus.wb_en),        32'd0);
    checkOutput("rst_wb_count",     32'(bus.wb_count),     32'd0);
    checkOutput("rst_load_pending", 32'(bus.load_pending), 32'd0);
    checkOutput("rst_wb_data",      32'(bus.wb_data),      32'h00);

    // Single ALU op: write appears two cycles after accept, for one cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 8'h5A);
    pushExp(3'd3, 8'h5A);
    step();
    idle();
    checkOutput("alu_wb_en_early", 32'(bus.wb_en), 32'd0);
    step();
    checkOutput("alu_wb_en",   32'(bus.wb_en),    32'd1);
    checkOutput("alu_wb_rd",   32'(bus.wb_rd),    32'd3);
    checkOutput("alu_wb_data", 32'(bus.wb_data),  32'h5A);
    step();
    checkOutput("alu_wb_en_off", 32'(bus.wb_en),    32'd0);
    checkOutput("alu_wb_count",  32'(bus.wb_count), 32'd1);

    // Load: memory data valid only the cycle after accept
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 8'h99);
    pushExp(3'd5, 8'hC3);
    step();
    idle();
    bus.memtoreg_in = 8'hC3;
    checkOutput("ld_pending", 32'(bus.load_pending), 32'd1);
    checkOutput("ld_rd",      32'(bus.load_rd),      32'd5);
    step();
    bus.memtoreg_in = 8'h00;
    checkOutput("ld_pending_off", 32'(bus.load_pending), 32'd0);
    checkOutput("ld_wb_en",       32'(bus.wb_en),        32'd1);
    checkOutput("ld_wb_rd",       32'(bus.wb_rd),        32'd5);
    checkOutput("ld_wb_data",     32'(bus.wb_data),      32'hC3);
    step();
    checkOutput("ld_wb_en_off", 32'(bus.wb_en),    32'd0);
    checkOutput("ld_wb_count",  32'(bus.wb_count), 32'd2);

    // Stalled load: data captured on first stalled edge, later change ignored
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'h00);
    pushExp(3'd2, 8'h11);
    step();
    idle();
    bus.memtoreg_in = 8'h11;
    bus.stall_in    = 1'b1;
    wbMark          = wbSeen;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stl_wb_en_hold", 32'(bus.wb_en),        32'd0);
      checkOutput("stl_pending",    32'(bus.load_pending), 32'd1);
    end
    bus.memtoreg_in = 8'hFF;
    bus.stall_in    = 1'b0;
    step();
    checkOutput("stl_wb_en",   32'(bus.wb_en),   32'd1);
    checkOutput("stl_wb_data", 32'(bus.wb_data), 32'h11);
    step();
    checkOutput("stl_wb_en_off", 32'(bus.wb_en), 32'd0);
    step();
    checkOutput("stl_pulses",   wbSeen - wbMark,         32'd1);
    checkOutput("stl_wb_count", 32'(bus.wb_count),       32'd3);

    // Mixed ALU / store / bubble / load sequence
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'h01);
    pushExp(3'd1, 8'h01);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd6, 8'h33);
    step();
    idle();
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 8'h55);
    pushExp(3'd4, 8'h7E);
    step();
    idle();
    bus.memtoreg_in = 8'h7E;
    step();
    bus.memtoreg_in = 8'h00;
    repeat (3) step();
    checkOutput("mix_sb_empty", sb.size(),         32'd0);
    checkOutput("mix_pulses",   wbSeen - wbMark,   32'd2);
    checkOutput("mix_wb_count", 32'(bus.wb_count), 32'd2);

    // Counter wrap: 65535 back-to-back ALU writes, then one more
    doReset();
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, RD_W'(i), DATA_W'(i * 7));
      pushExp(RD_W'(i), DATA_W'(i * 7));
      step();
    end
    idle();
    repeat (3) step();
    checkOutput("wrap_sb_empty",  sb.size(),         32'd0);
    checkOutput("wrap_pre_count", 32'(bus.wb_count), 32'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 8'hE7);
    pushExp(3'd7, 8'hE7);
    step();
    idle();
    repeat (3) step();
    checkOutput("wrap_count", 32'(bus.wb_count), 32'd0);

    // Reset while a load sits in s1: no write may follow
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 8'h00);
    step();
    idle();
    checkOutput("rmf_pending", 32'(bus.load_pending), 32'd1);
    bus.memtoreg_in = 8'h42;
    rst    = 1'b1;
    wbMark = wbSeen;
    step();
    rst = 1'b0;
    bus.memtoreg_in = 8'h00;
    checkOutput("rmf_pending_off", 32'(bus.load_pending), 32'd0);
    repeat (3) step();
    checkOutput("rmf_wb_en",    32'(bus.wb_en),    32'd0);
    checkOutput("rmf_pulses",   wbSeen - wbMark,   32'd0);
    checkOutput("rmf_wb_count", 32'(bus.wb_count), 32'd0);
    checkOutput("rmf_sb_empty", sb.size(),         32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertsRun, failures);
    $finish;
  end

endmodule
